// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared alu_arbiter.
interface alu_arbiter_if #(
    parameter int unsigned W = 64
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_fun0;
    logic [3:0]   req_fun1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_cc;
    logic         rsp_err;

    modport master (
        output req_valid, req_fun0, req_fun1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cc, rsp_err
    );

    modport slave (
        input  req_valid, req_fun0, req_fun1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cc, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Y86-64 ALU (ADD/SUB/AND/XOR) between two requesters;
// one operation in flight, result and condition codes returned from registers.
module alu_arbiter #(
    parameter int unsigned W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e       state_q, state_d;
    logic         prio_q, prio_d;
    logic         gnt_q, gnt_d;
    logic [3:0]   fun_q, fun_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] result_q, result_d;
    logic [2:0]   cc_q, cc_d;
    logic         err_q, err_d;

    logic         gnt_idx;
    logic [W-1:0] alu_res;
    logic         alu_of;
    logic         alu_err;

    // On a tie the pointer decides; otherwise whoever is valid wins.
    assign gnt_idx = (&bus.req_valid) ? prio_q : bus.req_valid[1];

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_err = 1'b0;
        case (fun_q)
            4'd0: begin
                alu_res = b_q + a_q;
                alu_of  = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != b_q[W-1]);
            end
            4'd1: begin
                alu_res = b_q - a_q;
                alu_of  = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != b_q[W-1]);
            end
            4'd2:    alu_res = b_q & a_q;
            4'd3:    alu_res = b_q ^ a_q;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        gnt_d         = gnt_q;
        fun_d         = fun_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        cc_d          = cc_q;
        err_d         = err_q;
        bus.req_ready = 2'b00;
        case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    bus.req_ready = gnt_idx ? 2'b10 : 2'b01;
                    gnt_d         = gnt_idx;
                    fun_d         = gnt_idx ? bus.req_fun1 : bus.req_fun0;
                    a_d           = gnt_idx ? bus.req_a1 : bus.req_a0;
                    b_d           = gnt_idx ? bus.req_b1 : bus.req_b0;
                    state_d       = StExec;
                end
            end
            StExec: begin
                result_d = alu_res;
                cc_d     = alu_err ? 3'b100 : {(alu_res == '0), alu_res[W-1], alu_of};
                err_d    = alu_err;
                state_d  = StResp;
            end
            StResp: begin
                // Only the granted requester's rsp_ready closes the transaction.
                if (bus.rsp_ready[gnt_q]) begin
                    state_d = StIdle;
                    prio_d  = ~gnt_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            fun_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            fun_q    <= fun_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cc_q     <= cc_d;
            err_q    <= err_d;
        end
    end

    assign bus.rsp_valid  = (state_q == StResp) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = result_q;
    assign bus.rsp_cc     = cc_q;
    assign bus.rsp_err    = err_q;

endmodule
